// File: rtl/hella_cache_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : hella_cache_arbiter                                           |
// | Description : Round-robin arbiter sharing one HellaCache port between       |
// |               NUM_REQ masters. The source index is appended to the          |
// |               downstream tag, and late data/kill come from the source that  |
// |               was just accepted. Responses are routed back by tag.          |
// |               Optional macro HELLA_CACHE_ARB_OUTSTANDING_EN enables a       |
// |               per-master outstanding-request limit (MAX_OUTSTANDING).       |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module hella_cache_arbiter #(
   parameter int NUM_REQ         = 2,
   parameter int NUM_ADDR_BITS   = 32,
   parameter int NUM_DATA_BITS   = 32,
   parameter int NUM_TAG_BITS    = 7,
   parameter int MAX_OUTSTANDING = 4,
   localparam int SRC_BITS       = $clog2(NUM_REQ),
   localparam int UT             = NUM_TAG_BITS - SRC_BITS,
   localparam int MASK_BITS      = NUM_DATA_BITS / 8
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic [NUM_REQ-1:0]                m_req_valid,
   output logic [NUM_REQ-1:0]                m_req_ready,
   input  logic [NUM_REQ*NUM_ADDR_BITS-1:0]  m_req_addr,
   input  logic [NUM_REQ*UT-1:0]             m_req_tag,
   input  logic [NUM_REQ*5-1:0]              m_req_cmd,
   input  logic [NUM_REQ*3-1:0]              m_req_typ,
   input  logic [NUM_REQ*NUM_DATA_BITS-1:0]  m_req_data,
   input  logic [NUM_REQ*MASK_BITS-1:0]      m_req_data_mask,
   input  logic [NUM_REQ-1:0]                m_req_kill,
   output logic [NUM_REQ-1:0]                m_rsp_valid,
   output logic [NUM_REQ-1:0]                m_rsp_nack,
   output logic [UT-1:0]                     m_rsp_tag,
   output logic [2:0]                        m_rsp_typ,
   output logic [NUM_DATA_BITS-1:0]          m_rsp_data,
   output logic                              req_valid,
   input  logic                              req_ready,
   output logic [NUM_ADDR_BITS-1:0]          req_addr,
   output logic [NUM_TAG_BITS-1:0]           req_tag,
   output logic [4:0]                        req_cmd,
   output logic [2:0]                        req_typ,
   output logic [NUM_DATA_BITS-1:0]          req_data,
   output logic [MASK_BITS-1:0]              req_data_mask,
   output logic                              req_kill,
   input  logic                              rsp_valid,
   input  logic                              rsp_nack,
   input  logic [NUM_TAG_BITS-1:0]           rsp_tag,
   input  logic [2:0]                        rsp_typ,
   input  logic [NUM_DATA_BITS-1:0]          rsp_data
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_LOCK = 1'b1;

   logic [NUM_ADDR_BITS-1:0] w_addr [NUM_REQ];
   logic [UT-1:0]            w_tag  [NUM_REQ];
   logic [4:0]               w_cmd  [NUM_REQ];
   logic [2:0]               w_typ  [NUM_REQ];
   logic [NUM_DATA_BITS-1:0] w_data [NUM_REQ];
   logic [MASK_BITS-1:0]     w_mask [NUM_REQ];

   logic [0:0]          r_state;
   logic [0:0]          w_state_next;
   logic [SRC_BITS-1:0] r_rr_ptr;
   logic [SRC_BITS-1:0] r_lock_src;
   logic [SRC_BITS-1:0] r_dsrc;
   logic                r_dvld;

   logic [NUM_REQ-1:0]  w_elig;
   logic                w_found;
   logic [SRC_BITS-1:0] w_scan_grant;
   logic [SRC_BITS-1:0] w_grant;
   logic [SRC_BITS-1:0] w_ptr_next;
   logic                w_lock;
   logic                w_req_valid;
   logic                w_accept;
   logic                w_stall;

   genvar gi;
   for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_addr[gi] = m_req_addr[gi*NUM_ADDR_BITS +: NUM_ADDR_BITS];
      assign w_tag[gi]  = m_req_tag[gi*UT +: UT];
      assign w_cmd[gi]  = m_req_cmd[gi*5 +: 5];
      assign w_typ[gi]  = m_req_typ[gi*3 +: 3];
      assign w_data[gi] = m_req_data[gi*NUM_DATA_BITS +: NUM_DATA_BITS];
      assign w_mask[gi] = m_req_data_mask[gi*MASK_BITS +: MASK_BITS];
   end

`ifdef HELLA_CACHE_ARB_OUTSTANDING_EN
   localparam int CNT_BITS = $clog2(MAX_OUTSTANDING + 1);
   logic [CNT_BITS-1:0] r_cnt [NUM_REQ];

   // A full master stays out of the scan; an existing lock still wins.
   for (gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
      logic w_inc;
      logic w_dec;
      assign w_inc = w_accept & (w_grant == SRC_BITS'(gi));
      assign w_dec = (m_rsp_valid[gi] | m_rsp_nack[gi]) & (r_cnt[gi] != '0);
      assign w_elig[gi] = m_req_valid[gi] & (r_cnt[gi] != CNT_BITS'(MAX_OUTSTANDING));

      always_ff @(posedge clock) begin
         if (reset) begin
            r_cnt[gi] <= '0;
         end else if (w_inc & ~w_dec) begin
            r_cnt[gi] <= r_cnt[gi] + 1'b1;
         end else if (w_dec & ~w_inc) begin
            r_cnt[gi] <= r_cnt[gi] - 1'b1;
         end
      end
   end
`else
   assign w_elig = m_req_valid;
`endif

   // Round-robin scan starting at r_rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      logic [SRC_BITS:0] idx;
      w_found      = 1'b0;
      w_scan_grant = '0;
      idx          = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = {1'b0, r_rr_ptr} + (SRC_BITS+1)'(k);
         if (idx >= (SRC_BITS+1)'(NUM_REQ)) begin
            idx = idx - (SRC_BITS+1)'(NUM_REQ);
         end
         if (!w_found && w_elig[idx[SRC_BITS-1:0]]) begin
            w_found      = 1'b1;
            w_scan_grant = idx[SRC_BITS-1:0];
         end
      end
   end

   always_comb begin
      logic [SRC_BITS:0] nxt;
      nxt = {1'b0, w_grant} + 1'b1;
      if (nxt >= (SRC_BITS+1)'(NUM_REQ)) begin
         nxt = '0;
      end
      w_ptr_next = nxt[SRC_BITS-1:0];
   end

   assign w_lock      = (r_state == ST_LOCK);
   assign w_grant     = w_lock ? r_lock_src : w_scan_grant;
   assign w_req_valid = ~reset & (w_lock ? m_req_valid[r_lock_src] : w_found);
   assign w_accept    = w_req_valid & req_ready;
   assign w_stall     = w_req_valid & ~req_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (w_stall)  w_state_next = ST_LOCK;
         ST_LOCK: if (w_accept) w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_rr_ptr   <= '0;
         r_lock_src <= '0;
         r_dsrc     <= '0;
         r_dvld     <= 1'b0;
      end else begin
         if (w_stall) begin
            r_lock_src <= w_grant;
         end
         if (w_accept) begin
            r_rr_ptr <= w_ptr_next;
            r_dsrc   <= w_grant;
         end
         r_dvld <= w_accept;
      end
   end

   always_comb begin
      req_valid     = 1'b0;
      req_addr      = '0;
      req_tag       = '0;
      req_cmd       = '0;
      req_typ       = '0;
      req_data_mask = '0;
      req_data      = '0;
      req_kill      = 1'b0;
      m_req_ready   = '0;
      m_rsp_valid   = '0;
      m_rsp_nack    = '0;
      m_rsp_tag     = '0;
      m_rsp_typ     = '0;
      m_rsp_data    = '0;
      if (!reset) begin
         req_valid = w_req_valid;
         if (w_req_valid) begin
            req_addr      = w_addr[w_grant];
            req_tag       = {w_tag[w_grant], w_grant};
            req_cmd       = w_cmd[w_grant];
            req_typ       = w_typ[w_grant];
            req_data_mask = w_mask[w_grant];
         end
         if (r_dvld) begin
            req_data = w_data[r_dsrc];
            req_kill = m_req_kill[r_dsrc];
         end
         // Tags whose source field is out of range match no master and vanish.
         for (int i = 0; i < NUM_REQ; i++) begin
            m_req_ready[i] = w_accept & (w_grant == SRC_BITS'(i));
            m_rsp_valid[i] = rsp_valid & (rsp_tag[SRC_BITS-1:0] == SRC_BITS'(i));
            m_rsp_nack[i]  = rsp_nack & (rsp_tag[SRC_BITS-1:0] == SRC_BITS'(i));
         end
         m_rsp_tag  = rsp_tag[NUM_TAG_BITS-1:SRC_BITS];
         m_rsp_typ  = rsp_typ;
         m_rsp_data = rsp_data;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hella_cache_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_hella_cache_arbiter                                        |
// | Description : Directed scoreboard bench for hella_cache_arbiter (2 masters).|
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_hella_cache_arbiter;

   localparam int MAX_OUT = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  m_req_valid, m_req_ready, m_req_kill;
   logic [63:0] m_req_addr, m_req_data;
   logic [11:0] m_req_tag;
   logic [9:0]  m_req_cmd;
   logic [5:0]  m_req_typ;
   logic [7:0]  m_req_data_mask;
   logic [1:0]  m_rsp_valid, m_rsp_nack;
   logic [5:0]  m_rsp_tag;
   logic [2:0]  m_rsp_typ, req_typ, rsp_typ;
   logic [31:0] m_rsp_data, req_addr, req_data, rsp_data;
   logic        req_valid, req_ready, req_kill, rsp_valid, rsp_nack;
   logic [6:0]  req_tag, rsp_tag;
   logic [4:0]  req_cmd;
   logic [3:0]  req_data_mask;

   hella_cache_arbiter #(
      .NUM_REQ(2), .NUM_ADDR_BITS(32), .NUM_DATA_BITS(32),
      .NUM_TAG_BITS(7), .MAX_OUTSTANDING(MAX_OUT)
   ) dut (
      .clock(clock), .reset(reset),
      .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
      .m_req_addr(m_req_addr), .m_req_tag(m_req_tag), .m_req_cmd(m_req_cmd),
      .m_req_typ(m_req_typ), .m_req_data(m_req_data),
      .m_req_data_mask(m_req_data_mask), .m_req_kill(m_req_kill),
      .m_rsp_valid(m_rsp_valid), .m_rsp_nack(m_rsp_nack), .m_rsp_tag(m_rsp_tag),
      .m_rsp_typ(m_rsp_typ), .m_rsp_data(m_rsp_data),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_tag(req_tag), .req_cmd(req_cmd), .req_typ(req_typ),
      .req_data(req_data), .req_data_mask(req_data_mask), .req_kill(req_kill),
      .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .rsp_tag(rsp_tag),
      .rsp_typ(rsp_typ), .rsp_data(rsp_data)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [6:0]  tag;
      logic [31:0] addr;
      logic [4:0]  cmd;
      logic [31:0] data;
      logic        kill;
      logic [1:0]  rdy;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        late_e;
   logic        late_pend = 1'b0;
   int          n_tests = 0;
   int          n_fail = 0;
   logic [5:0]  btag  [2];
   logic [31:0] baddr [2];
   logic [31:0] bdata [2];
   logic [4:0]  bcmd  [2];

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
      end
   endtask

   task automatic set_m(input int i, input logic [5:0] t, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] c);
      btag[i] = t; baddr[i] = a; bdata[i] = d; bcmd[i] = c;
      m_req_tag[i*6 +: 6]   = t;
      m_req_addr[i*32 +: 32] = a;
      m_req_data[i*32 +: 32] = d;
      m_req_cmd[i*5 +: 5]   = c;
      m_req_typ[i*3 +: 3]   = 3'd2;
   endtask

   function automatic exp_t mk(input int i, input logic k);
      exp_t e;
      e.tag  = {btag[i], 1'(i)};
      e.addr = baddr[i];
      e.cmd  = bcmd[i];
      e.data = bdata[i];
      e.kill = k;
      e.rdy  = 2'(1 << i);
      return e;
   endfunction

   // One cycle: settle, score outputs, advance to the next falling edge.
   task automatic cyc(input int wv);
      exp_t e;
      logic acc, have;
      #1;
      acc  = req_valid & req_ready;
      have = 1'b0;
      if (reset) begin
         chk("rst_req_valid", req_valid, 0);
         chk("rst_req_kill", req_kill, 0);
         chk("rst_req_tag", req_tag, 0);
         chk("rst_m_req_ready", m_req_ready, 0);
         chk("rst_m_rsp", {m_rsp_valid, m_rsp_nack}, 0);
         late_pend = 1'b0;
      end else begin
         if (wv >= 0) chk("req_valid", req_valid, 64'(wv));
         if (late_pend) begin
            chk("late_data", req_data, late_e.data);
            chk("late_kill", req_kill, late_e.kill);
         end else begin
            chk("idle_data", req_data, 0);
            chk("idle_kill", req_kill, 0);
         end
         if (req_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_req", req_valid, 0);
            end else begin
               e = exp_q[0];
               have = 1'b1;
               chk("req_tag", req_tag, e.tag);
               chk("req_addr", req_addr, e.addr);
               chk("req_cmd", req_cmd, e.cmd);
               if (acc) begin
                  chk("m_req_ready", m_req_ready, e.rdy);
                  void'(exp_q.pop_front());
               end
            end
         end
         if (!acc) chk("m_req_ready_idle", m_req_ready, 0);
         late_pend = acc & have;
         if (late_pend) late_e = e;
      end
      @(negedge clock);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; m_req_valid = '0; m_req_kill = '0; m_req_addr = '0; m_req_data = '0;
      m_req_tag = '0; m_req_cmd = '0; m_req_typ = '0; m_req_data_mask = 8'h3F;
      req_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_tag = '0;
      rsp_typ = '0; rsp_data = '0;
      set_m(0, 6'd5,  32'h0000_1000, 32'hDEAD_BEEF, 5'h01);
      set_m(1, 6'h2A, 32'h0000_2000, 32'hCAFE_F00D, 5'h00);
      @(negedge clock);
      cyc(0); cyc(0);
      reset = 1'b0;

      // single m0 request: tag {5,0}=0x0A, data next cycle
      req_ready = 1'b1;
      m_req_valid = 2'b01; exp_q.push_back(mk(0, 1'b0)); cyc(1);
      m_req_valid = 2'b00; cyc(0);
      m_req_valid = 2'b10; exp_q.push_back(mk(1, 1'b0)); cyc(1);
      m_req_valid = 2'b00; cyc(0);

      // continuous contention with m1 killing its own late phases
      m_req_kill = 2'b10; m_req_valid = 2'b11;
      exp_q.push_back(mk(0, 1'b0)); exp_q.push_back(mk(1, 1'b1));
      exp_q.push_back(mk(0, 1'b0)); exp_q.push_back(mk(1, 1'b1));
      cyc(1); cyc(1); cyc(1); cyc(1);
      m_req_valid = 2'b00; cyc(0); cyc(0);
      m_req_kill = 2'b00;

      // downstream stall holds grant 0, then 0 and 1 accepted
      req_ready = 1'b0; m_req_valid = 2'b11;
      exp_q.push_back(mk(0, 1'b0)); exp_q.push_back(mk(1, 1'b0));
      cyc(1); cyc(1); cyc(1);
      req_ready = 1'b1; cyc(1); cyc(1);
      m_req_valid = 2'b00; cyc(0);

      // response routing by tag
      rsp_valid = 1'b1; rsp_tag = 7'h0B; rsp_data = 32'h1234; rsp_typ = 3'd3;
      #1;
      chk("rsp_valid_route", m_rsp_valid, 2'b10);
      chk("rsp_nack_idle", m_rsp_nack, 2'b00);
      chk("rsp_tag", m_rsp_tag, 6'd5);
      chk("rsp_data", m_rsp_data, 32'h1234);
      chk("rsp_typ", m_rsp_typ, 3'd3);
      @(negedge clock);
      rsp_valid = 1'b0; rsp_nack = 1'b1; rsp_tag = 7'h04;
      #1;
      chk("nack_route", m_rsp_nack, 2'b01);
      chk("nack_valid_idle", m_rsp_valid, 2'b00);
      chk("nack_tag", m_rsp_tag, 6'd2);
      @(negedge clock);
      rsp_nack = 1'b0;

      // reset during a stall on m1 clears lock and pointer
      m_req_valid = 2'b11; exp_q.push_back(mk(0, 1'b0)); cyc(1);
      req_ready = 1'b0; exp_q.push_back(mk(1, 1'b0)); cyc(1); cyc(1);
      reset = 1'b1; exp_q.delete(); cyc(0);
      reset = 1'b0; req_ready = 1'b1;
      exp_q.push_back(mk(0, 1'b0)); exp_q.push_back(mk(1, 1'b0));
      cyc(1); cyc(1);
      m_req_valid = 2'b00; cyc(0);

`ifdef HELLA_CACHE_ARB_OUTSTANDING_EN
      // outstanding limit: m0 full blocks, m1 served, a response frees m0
      reset = 1'b1; cyc(0);
      reset = 1'b0; m_req_valid = 2'b01;
      for (int n = 0; n < MAX_OUT; n++) begin
         exp_q.push_back(mk(0, 1'b0)); cyc(1);
      end
      cyc(0);
      m_req_valid = 2'b11; exp_q.push_back(mk(1, 1'b0)); cyc(1);
      m_req_valid = 2'b01; rsp_valid = 1'b1; rsp_tag = 7'h00; cyc(0);
      rsp_valid = 1'b0; exp_q.push_back(mk(0, 1'b0)); cyc(1);
      m_req_valid = 2'b00; cyc(0);
`endif

      chk("queue_empty", 64'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
